// File: rtl/conv_window_scheduler_pkg.sv
// Shared definitions for the convolution window scheduler: FSM states, lane
// count and lane-index width helpers.
package conv_window_scheduler_pkg;

    typedef enum logic [2:0] {
        LOAD_FILTER,
        LOAD_DATA,
        MULT,
        WAIT_MULT,
        ADD,
        WAIT_ADD,
        OUTPUT
    } state_e;

    function automatic int unsigned lane_count(input int unsigned kernel);
        return kernel * kernel;
    endfunction

    function automatic int unsigned lane_idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int unsigned KERNELSIZE_DEFAULT = 3;
    localparam int unsigned N_LANES_DEFAULT    = lane_count(KERNELSIZE_DEFAULT);
    localparam int unsigned LANE_IDX_W_DEFAULT = lane_idx_width(N_LANES_DEFAULT);

endpackage

// File: rtl/conv_lane_loader.sv
// Lane register bank filled in order by a wrapping index counter; last_o flags
// the write that fills the final lane.
module conv_lane_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_LANES    = 9,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    output logic [N_LANES*DATA_WIDTH-1:0] lanes_o,
    output logic                          last_o
);

    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [N_LANES-1:0][DATA_WIDTH-1:0]    bank_q, bank_d;

    assign last_o  = wr_en_i && (idx_q == IDX_W'(N_LANES - 1));
    assign lanes_o = bank_q;

    always_comb begin
        idx_d  = idx_q;
        bank_d = bank_q;
        if (wr_en_i) begin
            bank_d[idx_q] = wr_data_i;
            idx_d         = last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            bank_q <= '0;
        end else begin
            idx_q  <= idx_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences filter/pixel loading, multiplier-array start/done collection, the
// final adder handshake and the result stream for one convolution window.
module conv_window_scheduler
    import conv_window_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KERNELSIZE = KERNELSIZE_DEFAULT
) (
    input  logic                                            axi_clk,
    input  logic                                            axi_reset_n,
    input  logic                                            s_axis_valid,
    input  logic [DATA_WIDTH-1:0]                           s_axis_data,
    output logic                                            s_axis_ready,
    input  logic                                            filter_reload,
    output logic [lane_count(KERNELSIZE)*DATA_WIDTH-1:0]    mult_a,
    output logic [lane_count(KERNELSIZE)*DATA_WIDTH-1:0]    mult_b,
    output logic [lane_count(KERNELSIZE)-1:0]               mult_start,
    input  logic [lane_count(KERNELSIZE)-1:0]               mult_done,
    output logic                                            add_start,
    input  logic                                            c_ready,
    input  logic [2*DATA_WIDTH-1:0]                         c_sum,
    output logic                                            m_axis_valid,
    output logic [DATA_WIDTH-1:0]                           m_axis_data,
    input  logic                                            m_axis_ready
);

    localparam int unsigned N     = lane_count(KERNELSIZE);
    localparam int unsigned IDX_W = lane_idx_width(N);

    state_e                 state_q;
    logic [N-1:0]           mask_q;
    logic [N-1:0]           mult_start_q;
    logic                   add_start_q;
    logic                   m_valid_q;
    logic [DATA_WIDTH-1:0]  m_data_q;

    logic                   in_load;
    logic                   filt_wr, data_wr;
    logic                   filt_last, data_last;
    logic [N-1:0]           mask_next;
    logic                   unused_csum_hi;

    // Gated by reset so the load states never advertise ready while held in reset.
    assign in_load      = (state_q == LOAD_FILTER) || (state_q == LOAD_DATA);
    assign s_axis_ready = axi_reset_n && in_load;
    assign filt_wr      = s_axis_valid && s_axis_ready && (state_q == LOAD_FILTER);
    assign data_wr      = s_axis_valid && s_axis_ready && (state_q == LOAD_DATA);
    assign mask_next    = mask_q | mult_done;
    assign unused_csum_hi = ^c_sum[2*DATA_WIDTH-1:DATA_WIDTH];

    conv_lane_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_LANES    (N),
        .IDX_W      (IDX_W)
    ) u_filter_loader (
        .clk_i      (axi_clk),
        .rst_ni     (axi_reset_n),
        .wr_en_i    (filt_wr),
        .wr_data_i  (s_axis_data),
        .lanes_o    (mult_b),
        .last_o     (filt_last)
    );

    conv_lane_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_LANES    (N),
        .IDX_W      (IDX_W)
    ) u_data_loader (
        .clk_i      (axi_clk),
        .rst_ni     (axi_reset_n),
        .wr_en_i    (data_wr),
        .wr_data_i  (s_axis_data),
        .lanes_o    (mult_a),
        .last_o     (data_last)
    );

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q      <= LOAD_FILTER;
            mask_q       <= '0;
            mult_start_q <= '0;
            add_start_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
        end else begin
            mult_start_q <= '0;
            add_start_q  <= 1'b0;
            unique case (state_q)
                LOAD_FILTER: if (filt_last) state_q <= LOAD_DATA;
                LOAD_DATA: begin
                    if (data_last) begin
                        state_q      <= MULT;
                        mult_start_q <= '1;
                    end
                end
                // Done pulses seen while the start burst is out are deliberately dropped.
                MULT: state_q <= WAIT_MULT;
                WAIT_MULT: begin
                    if (&mask_next) begin
                        mask_q  <= '0;
                        state_q <= ADD;
                    end else begin
                        mask_q  <= mask_next;
                    end
                end
                ADD: begin
                    if (!c_ready) begin
                        add_start_q <= 1'b1;
                        state_q     <= WAIT_ADD;
                    end
                end
                WAIT_ADD: begin
                    if (c_ready) begin
                        m_data_q  <= c_sum[DATA_WIDTH-1:0];
                        m_valid_q <= 1'b1;
                        state_q   <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (m_axis_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= filter_reload ? LOAD_FILTER : LOAD_DATA;
                    end
                end
                default: state_q <= LOAD_FILTER;
            endcase
        end
    end

    assign mult_start   = mult_start_q;
    assign add_start    = add_start_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: table-driven windows, a reset
// sequence and randomized windows against a dot-product reference model.
module tb_conv_window_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned KS = 3;
    localparam int unsigned N  = KS * KS;

    logic                axi_clk = 1'b0;
    logic                axi_reset_n = 1'b0;
    logic                s_axis_valid = 1'b0;
    logic [DW-1:0]       s_axis_data = '0;
    logic                s_axis_ready;
    logic                filter_reload = 1'b0;
    logic [N*DW-1:0]     mult_a, mult_b;
    logic [N-1:0]        mult_start;
    logic [N-1:0]        mult_done = '0;
    logic                add_start;
    logic                c_ready = 1'b0;
    logic [2*DW-1:0]     c_sum = '0;
    logic                m_axis_valid;
    logic [DW-1:0]       m_axis_data;
    logic                m_axis_ready = 1'b0;

    conv_window_scheduler #(
        .DATA_WIDTH (DW),
        .KERNELSIZE (KS)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_reset_n   (axi_reset_n),
        .s_axis_valid  (s_axis_valid),
        .s_axis_data   (s_axis_data),
        .s_axis_ready  (s_axis_ready),
        .filter_reload (filter_reload),
        .mult_a        (mult_a),
        .mult_b        (mult_b),
        .mult_start    (mult_start),
        .mult_done     (mult_done),
        .add_start     (add_start),
        .c_ready       (c_ready),
        .c_sum         (c_sum),
        .m_axis_valid  (m_axis_valid),
        .m_axis_data   (m_axis_data),
        .m_axis_ready  (m_axis_ready)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    int n_ms = 0, n_as = 0, n_bad_ms = 0;
    int checks = 0, errors = 0;

    always @(posedge axi_clk) cyc <= cyc + 1;

    always @(negedge axi_clk) begin
        if (axi_reset_n) begin
            if (mult_start == '1) n_ms <= n_ms + 1;
            else if (mult_start != '0) n_bad_ms <= n_bad_ms + 1;
            if (add_start) n_as <= n_as + 1;
        end
    end

    typedef struct {
        logic [N-1:0][DW-1:0] filt;
        logic [N-1:0][DW-1:0] data;
        logic                 reload_after;
        int unsigned          mode;   // 0: all done together, 1: scrambled one per cycle, 2: spurious early pulse
        int unsigned          dm;
        int unsigned          da;
        int unsigned          hold;
        int unsigned          stall;
        logic                 force_sum;
        logic [63:0]          sum_val;
        logic                 use_exp;
        logic [DW-1:0]        exp;
    } win_t;

    logic                 need_filter = 1'b1;
    logic [N-1:0][DW-1:0] mdl_filt = '0;
    logic [N-1:0][DW-1:0] mdl_data = '0;

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [N-1:0][DW-1:0] seqv(input int start, input int step);
        logic [N-1:0][DW-1:0] r;
        for (int k = 0; k < int'(N); k++) r[k] = DW'(start + step * k);
        return r;
    endfunction

    function automatic win_t mk(input logic [N-1:0][DW-1:0] f, input logic [N-1:0][DW-1:0] d,
                                input logic rl, input int unsigned mode, input int unsigned dm,
                                input int unsigned da, input int unsigned hold, input int unsigned stall,
                                input logic fs, input logic [63:0] sv, input logic [DW-1:0] e);
        win_t w;
        w.filt = f; w.data = d; w.reload_after = rl; w.mode = mode; w.dm = dm; w.da = da;
        w.hold = hold; w.stall = stall; w.force_sum = fs; w.sum_val = sv; w.use_exp = 1'b1; w.exp = e;
        return w;
    endfunction

    function automatic logic [63:0] model_dot();
        logic [63:0] s = '0;
        for (int k = 0; k < int'(N); k++) s += 64'(mdl_filt[k]) * 64'(mdl_data[k]);
        return s;
    endfunction

    // Environment adder: sums the lane products it is presented with.
    function automatic logic [63:0] adder_dot();
        logic [63:0] s = '0;
        for (int k = 0; k < int'(N); k++) s += 64'(mult_a[k*DW +: DW]) * 64'(mult_b[k*DW +: DW]);
        return s;
    endfunction

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) @(negedge axi_clk);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = w;
        while (!s_axis_ready && n < 20) begin
            @(negedge axi_clk);
            n++;
        end
        if (!s_axis_ready) chk("s_ready_timeout", {N*DW{1'b0}}, {{(N*DW-1){1'b0}}, 1'b1});
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        s_axis_data  = $urandom;
    endtask

    task automatic run_window(input win_t w);
        int t0, tdone, ta, tc, tv, ms0, as0, n;
        int perm[N];
        logic [DW-1:0] req;
        logic [N-1:0] md;
        ms0 = n_ms; as0 = n_as;
        if (w.hold > 0) begin
            c_ready = 1'b1;
            c_sum   = {$urandom, $urandom};
        end
        if (need_filter) begin
            for (int k = 0; k < int'(N); k++) begin idle_gap(); send_word(w.filt[k]); end
            mdl_filt = w.filt;
        end
        for (int k = 0; k < int'(N); k++) begin idle_gap(); send_word(w.data[k]); end
        mdl_data = w.data;
        req = w.use_exp ? w.exp : (w.force_sum ? w.sum_val[DW-1:0] : model_dot()[DW-1:0]);
        t0 = cyc;
        chk("mult_start_burst", mult_start, {N{1'b1}});
        chk("s_ready_in_mult", s_axis_ready, 0);
        chk("mult_a_lanes", mult_a, mdl_data);
        chk("mult_b_lanes", mult_b, mdl_filt);
        case (w.mode)
            1: begin
                for (int i = 0; i < int'(N); i++) perm[i] = i;
                for (int i = int'(N) - 1; i > 0; i--) begin
                    int j, t;
                    j = $urandom_range(0, i);
                    t = perm[i]; perm[i] = perm[j]; perm[j] = t;
                end
                for (int j = 0; j < int'(N); j++) begin
                    @(negedge axi_clk);
                    chk("add_start_early", add_start, 0);
                    md = '0;
                    md[perm[j]] = 1'b1;
                    mult_done = md;
                end
                tdone = int'(N);
            end
            2: begin
                mult_done = '1;
                for (int c = 1; c <= 4; c++) begin
                    @(negedge axi_clk);
                    mult_done = '0;
                    chk("spurious_done_ignored", add_start, 0);
                end
                mult_done = '1;
                tdone = 4;
            end
            default: begin
                repeat (w.dm) @(negedge axi_clk);
                mult_done = '1;
                tdone = int'(w.dm);
            end
        endcase
        @(negedge axi_clk);
        mult_done = '0;
        if (w.hold > 0) begin
            repeat (w.hold) begin
                chk("add_held_by_c_ready", add_start, 0);
                @(negedge axi_clk);
            end
            c_ready = 1'b0;
        end
        n = 0;
        while (!add_start && n < 40) begin @(negedge axi_clk); n++; end
        chk("add_start_seen", add_start, 1);
        ta = cyc - t0;
        if (w.hold == 0) chk("add_start_latency", ta, tdone + 2);
        repeat (w.da) @(negedge axi_clk);
        c_ready = 1'b1;
        c_sum   = w.force_sum ? w.sum_val : adder_dot();
        tc = cyc - t0;
        n = 0;
        do begin @(negedge axi_clk); n++; end while (!m_axis_valid && n < 40);
        chk("m_valid_seen", m_axis_valid, 1);
        tv = cyc - t0;
        chk("capture_latency", tv, tc + 1);
        if (w.hold == 0) chk("total_latency", tv, 3 + tdone + int'(w.da));
        chk("m_data", m_axis_data, req);
        chk("mult_a_stable", mult_a, mdl_data);
        chk("mult_b_stable", mult_b, mdl_filt);
        chk("s_ready_in_output", s_axis_ready, 0);
        filter_reload = w.reload_after;
        repeat (w.stall) begin
            @(negedge axi_clk);
            chk("stall_m_valid", m_axis_valid, 1);
            chk("stall_m_data", m_axis_data, req);
            chk("stall_s_ready", s_axis_ready, 0);
        end
        m_axis_ready = 1'b1;
        @(negedge axi_clk);
        m_axis_ready  = 1'b0;
        c_ready       = 1'b0;
        filter_reload = 1'($urandom);
        chk("m_valid_after_hs", m_axis_valid, 0);
        chk("s_ready_after_hs", s_axis_ready, 1);
        chk("mult_start_count", n_ms - ms0, 1);
        chk("add_start_count", n_as - as0, 1);
        need_filter = w.reload_after;
    endtask

    win_t tbl[6];
    win_t rw;

    initial begin
        tbl[0] = mk(seqv(1, 1), seqv(2, 0), 1'b0, 0, 2, 1, 0, 0,  1'b0, 64'd0, 32'd90);
        tbl[1] = mk(seqv(0, 0), seqv(1, 0), 1'b0, 0, 1, 2, 0, 0,  1'b0, 64'd0, 32'd45);
        tbl[2] = mk(seqv(0, 0), seqv(4, 0), 1'b0, 0, 3, 1, 0, 0,  1'b1, 64'h1_0000_0005, 32'h0000_0005);
        tbl[3] = mk(seqv(0, 0), seqv(3, 1), 1'b1, 0, 1, 1, 0, 10, 1'b0, 64'd0, 32'd375);
        tbl[4] = mk(seqv(9, -1), seqv(1, 1), 1'b0, 1, 1, 2, 0, 0, 1'b0, 64'd0, 32'd165);
        tbl[5] = mk(seqv(0, 0), seqv(5, 0), 1'b0, 2, 1, 1, 3, 1,  1'b0, 64'd0, 32'd225);

        #12;
        chk("rst_s_ready", s_axis_ready, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_add_start", add_start, 0);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_m_data", m_axis_data, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        @(negedge axi_clk);
        #2 axi_reset_n = 1'b1;
        @(negedge axi_clk);
        chk("s_ready_after_release", s_axis_ready, 1);

        for (int i = 0; i < 6; i++) run_window(tbl[i]);

        // Abort a partly loaded data window; the next words must land in the filter.
        for (int k = 0; k < 5; k++) send_word(32'd7);
        #2 axi_reset_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_axis_ready, 0);
        chk("mid_rst_mult_start", mult_start, 0);
        chk("mid_rst_add_start", add_start, 0);
        chk("mid_rst_m_valid", m_axis_valid, 0);
        chk("mid_rst_m_data", m_axis_data, 0);
        chk("mid_rst_mult_a", mult_a, 0);
        chk("mid_rst_mult_b", mult_b, 0);
        @(negedge axi_clk);
        #2 axi_reset_n = 1'b1;
        @(negedge axi_clk);
        need_filter = 1'b1;
        run_window(mk(seqv(2, 0), seqv(1, 1), 1'b0, 0, 2, 1, 0, 0, 1'b0, 64'd0, 32'd90));

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < int'(N); k++) begin
                rw.filt[k] = $urandom;
                rw.data[k] = $urandom;
            end
            rw.reload_after = 1'($urandom);
            rw.mode      = $urandom_range(0, 1);
            rw.dm        = $urandom_range(1, 4);
            rw.da        = $urandom_range(1, 3);
            rw.hold      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            rw.stall     = $urandom_range(0, 3);
            rw.force_sum = 1'b0;
            rw.sum_val   = '0;
            rw.use_exp   = 1'b0;
            rw.exp       = '0;
            run_window(rw);
        end

        chk("partial_mult_start", n_bad_ms, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
